// File: rtl/exp_acc_pkg.sv
// Shared types and widths for the exponential accelerator blocks.
// Anything that drives or consumes the exponential unit imports this package.
package exp_acc_pkg;

    localparam int EXP_XW = 16;
    localparam int EXP_IW = 2;
    localparam int EXP_FW = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        RESP      = 3'd4
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority picker: the first asserted request at or
// after ptr (wrapping modulo NREQ) wins.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            gnt_valid,
    output logic [IDW-1:0]  gnt_id
);

    function automatic logic [IDW-1:0] rot(input logic [IDW-1:0] base, input int off);
        int idx;
        idx = (int'(base) + off) % NREQ;
        return IDW'(idx);
    endfunction

    // Scan from the farthest offset down so the nearest request overwrites last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[rot(ptr, i)]) begin
                gnt_valid = 1'b1;
                gnt_id    = rot(ptr, i);
            end
        end
    end

endmodule

// File: rtl/exp_arbiter.sv
// Round-robin sharing of one exponential unit among NREQ requesters, with
// stale-done filtering and a watchdog that aborts a hung operation.
module exp_arbiter
    import exp_acc_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [EXP_XW*NREQ-1:0] x_in,
    output logic [NREQ-1:0]        ack,
    output logic [EXP_IW-1:0]      res_int,
    output logic [EXP_FW-1:0]      res_frac,
    output logic [IDW-1:0]         res_id,
    output logic                   res_err,
    output logic                   busy,
    output logic [EXP_XW-1:0]      exp_x,
    output logic                   exp_start,
    input  logic                   exp_done,
    input  logic [EXP_IW-1:0]      exp_intpart,
    input  logic [EXP_FW-1:0]      exp_fracpart
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

    arb_state_t     state, state_n;
    logic [IDW-1:0] rr_ptr, cur_id, gnt_id;
    logic [WDW-1:0] wdog;
    logic           gnt_valid, wd_expired;
    logic           load_op, wdog_clr, wdog_inc, cap_ok, cap_err, rr_adv;

    rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
        .req       (req),
        .ptr       (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign wd_expired = (wdog == WD_MAX);
    assign busy       = (state != IDLE);
    assign exp_start  = (state == START);

    always_comb begin
        ack = '0;
        if (state == RESP) ack[cur_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // A done already high on entry to WAIT_LOW belongs to the previous op.
    always_comb begin
        state_n  = state;
        load_op  = 1'b0;
        wdog_clr = 1'b0;
        wdog_inc = 1'b0;
        cap_ok   = 1'b0;
        cap_err  = 1'b0;
        rr_adv   = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    load_op = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                wdog_clr = 1'b1;
                state_n  = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!exp_done) begin
                    wdog_clr = 1'b1;
                    state_n  = WAIT_HIGH;
                end else if (wd_expired) begin
                    cap_err = 1'b1;
                    state_n = RESP;
                end else begin
                    wdog_inc = 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (exp_done) begin
                    cap_ok  = 1'b1;
                    state_n = RESP;
                end else if (wd_expired) begin
                    cap_err = 1'b1;
                    state_n = RESP;
                end else begin
                    wdog_inc = 1'b1;
                end
            end
            RESP: begin
                rr_adv  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr   <= '0;
            cur_id   <= '0;
            exp_x    <= '0;
            wdog     <= '0;
            res_int  <= '0;
            res_frac <= '0;
            res_id   <= '0;
            res_err  <= 1'b0;
        end else begin
            if (load_op) begin
                cur_id <= gnt_id;
                exp_x  <= x_in[int'(gnt_id)*EXP_XW +: EXP_XW];
            end
            if (wdog_clr)      wdog <= '0;
            else if (wdog_inc) wdog <= wdog + 1'b1;
            if (cap_ok) begin
                res_int  <= exp_intpart;
                res_frac <= exp_fracpart;
                res_id   <= cur_id;
                res_err  <= 1'b0;
            end else if (cap_err) begin
                res_int  <= '0;
                res_frac <= '0;
                res_id   <= cur_id;
                res_err  <= 1'b1;
            end
            // The requester just served drops to lowest priority.
            if (rr_adv) rr_ptr <= (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + 1'b1;
        end
    end

endmodule

// File: tb/tb_exp_arbiter.sv
// Directed scoreboard bench for exp_arbiter with a behavioural exponential stub
// (intpart = x[1:0], frac = ~x) whose latency, done-drop delay and hang are programmable.
module tb_exp_arbiter;
    import exp_acc_pkg::*;

    localparam int NREQ   = 4;
    localparam int IDW    = 2;
    localparam int TO     = 15;
    localparam int SBW    = EXP_XW + IDW + EXP_IW + EXP_FW + 1;
    localparam int ID_LSB = EXP_FW + EXP_IW + 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [EXP_XW-1:0]      xs [NREQ];
    logic [EXP_XW*NREQ-1:0] x_in;
    logic [NREQ-1:0]        ack;
    logic [EXP_IW-1:0]      res_int;
    logic [EXP_FW-1:0]      res_frac;
    logic [IDW-1:0]         res_id;
    logic                   res_err, busy, exp_start, exp_done;
    logic [EXP_XW-1:0]      exp_x;
    logic [EXP_IW-1:0]      exp_intpart;
    logic [EXP_FW-1:0]      exp_fracpart;

    exp_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .x_in         (x_in),
        .ack          (ack),
        .res_int      (res_int),
        .res_frac     (res_frac),
        .res_id       (res_id),
        .res_err      (res_err),
        .busy         (busy),
        .exp_x        (exp_x),
        .exp_start    (exp_start),
        .exp_done     (exp_done),
        .exp_intpart  (exp_intpart),
        .exp_fracpart (exp_fracpart)
    );

    always_comb begin
        x_in = '0;
        for (int i = 0; i < NREQ; i++) x_in[i*EXP_XW +: EXP_XW] = xs[i];
    end

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- exponential stub ----------------
    int          lat = 8;
    int          drop_delay = 0;
    bit          never = 1'b0;
    int          scnt;
    bit          srun;
    logic [15:0] sx;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_done <= 1'b0; exp_intpart <= '0; exp_fracpart <= '0;
            srun <= 1'b0; scnt <= 0; sx <= '0;
        end else if (exp_start) begin
            sx <= exp_x; srun <= 1'b1; scnt <= 1;
            if (drop_delay == 0) exp_done <= 1'b0;
        end else if (srun) begin
            scnt <= scnt + 1;
            if (scnt == drop_delay) exp_done <= 1'b0;
            if (!never && scnt == lat) begin
                exp_done <= 1'b1; exp_intpart <= sx[1:0]; exp_fracpart <= ~sx; srun <= 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [SBW-1:0]    exp_q[$];
    logic [EXP_XW-1:0] start_q[$];
    int n_checks = 0, n_fail = 0, n_starts = 0;
    int last_start_cyc = 0, last_ack_cyc = 0;
    int rem [NREQ];

    function automatic logic [SBW-1:0] mk(input logic [15:0] x, input logic [IDW-1:0] id,
                                          input logic [1:0] ip, input logic [15:0] fp, input logic e);
        return {x, id, ip, fp, e};
    endfunction

    // Monitor: every start pulse and every ack is checked against the queues.
    initial forever begin
        logic [SBW-1:0]  rec, act;
        logic [NREQ-1:0] oh;
        @(negedge clk);
        if (rst) begin
            if (exp_start) begin
                n_checks++; n_starts++; last_start_cyc = cyc;
                if (start_q.size() == 0) begin
                    n_fail++; $display("FAIL start_unexpected: exp_x=%h, required no start", exp_x);
                end else begin
                    logic [15:0] ex;
                    ex = start_q.pop_front();
                    if (exp_x !== ex) begin
                        n_fail++; $display("FAIL start_operand: exp_x=%h, required %h", exp_x, ex);
                    end
                end
            end
            if (ack != '0) begin
                n_checks++; last_ack_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL ack_unexpected: ack=%b id=%0d, required no ack", ack, res_id);
                end else begin
                    rec = exp_q.pop_front();
                    oh  = NREQ'(1) << rec[ID_LSB +: IDW];
                    act = {exp_x, res_id, res_int, res_frac, res_err};
                    if (act !== rec || ack !== oh) begin
                        n_fail++;
                        $display("FAIL ack_result: ack=%b id=%0d int=%b frac=%h err=%b x=%h, required ack=%b id=%0d int=%b frac=%h err=%b x=%h",
                                 ack, res_id, res_int, res_frac, res_err, exp_x,
                                 oh, rec[ID_LSB +: IDW], rec[EXP_FW+1 +: EXP_IW], rec[1 +: EXP_FW], rec[0], rec[SBW-1 -: EXP_XW]);
                    end
                end
            end
        end
    end

    // Requester model: drops req[i] once its remaining grant count reaches zero.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i] && rem[i] > 0) begin
                rem[i]--;
                if (rem[i] == 0) req[i] = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++; $display("FAIL %s: got %0h, required %0h", name, act, expv);
        end
    endtask

    task automatic issue(input int id, input logic [15:0] x, input int n);
        xs[id] = x; rem[id] = n; req[id] = 1'b1;
    endtask

    task automatic expect_op(input logic [15:0] x, input int id, input logic [1:0] ip,
                             input logic [15:0] fp, input logic e);
        start_q.push_back(x);
        exp_q.push_back(mk(x, IDW'(id), ip, fp, e));
    endtask

    task automatic drain(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0 && start_q.size() == 0 && !busy) break;
        end
        if (i == budget) begin
            n_checks++; n_fail++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", name, exp_q.size());
            exp_q.delete(); start_q.delete();
        end
    endtask

    task automatic wait_start(input string name, input int budget);
        int n0, i;
        n0 = n_starts;
        for (i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (n_starts > n0) break;
        end
        if (i == budget) begin
            n_checks++; n_fail++; $display("FAIL %s_start: no start seen, required one", name);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b0; req = '0;
        for (int i = 0; i < NREQ; i++) begin xs[i] = '0; rem[i] = 0; end
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_start", exp_start, 0);
        check("rst_res", {res_int, res_frac, res_id, res_err}, 0);
        check("rst_exp_x", exp_x, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // All four at once from rr_ptr=0: served 0,1,2,3.
        expect_op(16'h3333, 0, 2'b11, 16'hCCCC, 1'b0);
        expect_op(16'hCCCC, 1, 2'b00, 16'h3333, 1'b0);
        expect_op(16'hFD70, 2, 2'b00, 16'h028F, 1'b0);
        expect_op(16'h028F, 3, 2'b11, 16'hFD70, 1'b0);
        issue(0, 16'h3333, 1); issue(1, 16'hCCCC, 1); issue(2, 16'hFD70, 1); issue(3, 16'h028F, 1);
        drain("all_four", 400);

        // Single request; operand changes mid-operation but exp_x must hold.
        @(negedge clk);
        expect_op(16'h8000, 2, 2'b00, 16'h7FFF, 1'b0);
        issue(2, 16'h8000, 1);
        repeat (4) @(negedge clk);
        xs[2] = 16'h1111;
        drain("single", 100);
        check("single_latency", last_ack_cyc - last_start_cyc, 10);

        // Both held: ptr=3 so 0 first, then strict alternation.
        @(negedge clk);
        expect_op(16'h0101, 0, 2'b01, 16'hFEFE, 1'b0);
        expect_op(16'h0202, 1, 2'b10, 16'hFDFD, 1'b0);
        expect_op(16'h0101, 0, 2'b01, 16'hFEFE, 1'b0);
        expect_op(16'h0202, 1, 2'b10, 16'hFDFD, 1'b0);
        issue(0, 16'h0101, 2); issue(1, 16'h0202, 2);
        drain("alternate", 400);

        // Stale done: done stays high from the previous op for 3 cycles after start.
        @(negedge clk);
        expect_op(16'h1234, 1, 2'b00, 16'hEDCB, 1'b0);
        issue(1, 16'h1234, 1);
        drain("stale_a", 100);
        drop_delay = 3;
        expect_op(16'h00F1, 3, 2'b01, 16'hFF0E, 1'b0);
        issue(3, 16'h00F1, 1);
        drain("stale_b", 100);
        check("stale_latency", last_ack_cyc - last_start_cyc, 10);
        drop_delay = 0;

        // Hung unit: abort after wdog reaches TIMEOUT, then a normal op.
        @(negedge clk);
        never = 1'b1;
        expect_op(16'hABCD, 0, 2'b00, 16'h0000, 1'b1);
        issue(0, 16'hABCD, 1);
        drain("timeout", 200);
        check("timeout_latency", last_ack_cyc - last_start_cyc, TO + 3);
        never = 1'b0;
        @(negedge clk);
        expect_op(16'h0007, 2, 2'b11, 16'hFFF8, 1'b0);
        issue(2, 16'h0007, 1);
        drain("after_timeout", 100);

        // Reset in WAIT_HIGH: no ack, and arbitration restarts from rr_ptr=0.
        @(negedge clk);
        start_q.push_back(16'h4242);
        issue(1, 16'h4242, 1);
        wait_start("reset_op", 20);
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        req = '0;
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_ack", ack, 0);
        check("midrst_start", exp_start, 0);
        #2 rst = 1'b1;
        @(negedge clk);
        check("post_rst_start", exp_start, 0);
        check("post_rst_busy", busy, 0);
        expect_op(16'h5555, 0, 2'b01, 16'hAAAA, 1'b0);
        expect_op(16'hAAAA, 3, 2'b10, 16'h5555, 1'b0);
        issue(0, 16'h5555, 1); issue(3, 16'hAAAA, 1);
        drain("post_reset", 200);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exp_arbiter.md
Name: exp_arbiter

Overview:
Round-robin arbiter and sequencer that shares one `exponential` unit among NREQ requesters in the FPGA accelerator. It latches the winning requester's operand and drives the unit's start/done handshake. It returns the 2-bit integer and 16-bit fractional result to the winner on a shared result bus with a one-hot ack. A watchdog aborts any operation whose done never arrives.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester index width, clog2(NREQ)
TIMEOUT, 1023, max cycles waited in each WAIT state before abort

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
req  in  NREQ  per-requester request level; held with operand until its ack
x_in  in  16*NREQ  operands, requester i at bits [16i+15:16i]
ack  out  NREQ  one-hot, one-cycle pulse when the result for requester i is on the bus
res_int  out  2  integer part of result
res_frac  out  16  fractional part of result
res_id  out  IDW  index of the acked requester
res_err  out  1  high with ack if the operation timed out (result fields = 0)
busy  out  1  high in every state except IDLE
exp_x  out  16  operand to exponential, stable from START until the result is taken
exp_start  out  1  one-cycle start pulse to exponential
exp_done  in  1  done from exponential (level; may still be high from previous op)
exp_intpart  in  2  exponential integer result
exp_fracpart  in  16  exponential fractional result

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, all outputs 0, wdog=0.
- States: IDLE, START, WAIT_LOW, WAIT_HIGH, RESP.
- IDLE:
  - If any req is high, pick the first asserted index scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - Register cur_id and exp_x <= x_in[cur_id], then go to START.
- START: exp_start=1 for exactly this cycle. wdog<=0. Go to WAIT_LOW.
- WAIT_LOW: wait for exp_done==0; this discards a stale done from the previous op. When seen, wdog<=0 and go to WAIT_HIGH.
- WAIT_HIGH: wait for exp_done==1. Then register res_int/res_frac from exp_intpart/exp_fracpart, res_id=cur_id, res_err=0, and go to RESP.
- Watchdog: in WAIT_LOW and WAIT_HIGH, wdog increments each cycle. When wdog==TIMEOUT, go to RESP with res_err=1 and res_int=res_frac=0.
- RESP:
  - ack[cur_id]=1 for one cycle.
  - rr_ptr <= (cur_id+1) mod NREQ, so the granted requester gets lowest priority next time.
  - Go to IDLE.
  - res_* hold their value until the next RESP.
- Minimum latency from req sampled in IDLE to ack: 4 cycles + exponential compute time.
- Requester rule: deassert req in the cycle after ack, otherwise it re-enters arbitration. x_in[i] must be stable while req[i]=1.
- A req that drops before it is granted is simply skipped. A req dropped after grant still completes and is acked; the requester ignores the ack.
- Simultaneous requests are served strictly round-robin; no requester waits more than NREQ-1 operations.
- exp_x does not change between START and RESP, even if x_in changes.
- Reset mid-operation returns to IDLE immediately, with no ack for the aborted request. exp_start is never asserted during or directly after reset.

Decomposition:
- Shared package exp_acc_pkg holds:
  - state encoding constants (IDLE=0 .. RESP=4)
  - EXP_XW=16, EXP_IW=2, EXP_FW=16
- One sub-module, rr_picker: combinational priority rotate.
  - Inputs: req, ptr. Outputs: gnt_valid, gnt_id.
  - Reused by later shared-resource arbiters.
- Watchdog counter and FSM stay in exp_arbiter.

Test Plan:
Use a behavioural exponential stub: on start it drops done next cycle, raises done after LAT cycles, and returns intpart=x[1:0], frac=~x.
- Single request: req[2]=1, x=16'h8000, LAT=8 -> exactly one ack=4'b0100, res_id=2, res_int=2'b00, res_frac=16'h7FFF, res_err=0; exp_start pulses once with exp_x=16'h8000.
- All four requests at once, operands 16'h3333/16'hCCCC/16'hFD70/16'h028F, rr_ptr=0 -> acks in order 0,1,2,3. Requester 3 gets res_frac=16'hFD70 and res_int=2'b11.
- Back-to-back starvation check: req0 re-asserted immediately after each ack while req1 is held -> grants alternate 0,1,0,1.
- Stale done: stub keeps done=1 between ops -> no ack until done has gone low and back high; second result is the new one, not the previous one.
- Timeout with TIMEOUT=15: stub never raises done -> ack after WAIT_HIGH wdog reaches 15, with res_err=1 and res_int/res_frac=0; the arbiter then serves the next request normally.
- Reset mid-WAIT_HIGH: rst=0 for 3 ns -> busy=0 and ack=0 at once; after release, a new request is granted starting from rr_ptr=0.
